// File: rtl/shift_engine_if.sv
// shift_engine_if
// ---------------
// FIFO-side bundle for the ISR/OSR shift engine. It groups the RX write port
// and the TX read port that connect a state machine's shift engine to its
// per-machine FIFOs.
//
// Handshake: a word moves into the RX FIFO in any cycle where rx_push is high.
// The engine never raises rx_push while rx_full is high. A word leaves the TX
// FIFO in any cycle where tx_pop is high. The engine never raises tx_pop while
// tx_empty is high. tx_data is the current head word and is valid whenever
// tx_empty is low. Both strobes may be high in the same cycle.
//
// Signals:
//   rx_full  (FIFO -> engine)  RX FIFO cannot accept a word
//   rx_push  (engine -> FIFO)  RX write strobe
//   rx_data  (engine -> FIFO)  RX write data
//   tx_empty (FIFO -> engine)  TX FIFO holds no word
//   tx_data  (FIFO -> engine)  TX head word
//   tx_pop   (engine -> FIFO)  TX read strobe
interface shift_engine_if #(
    parameter int DATA_W = 32
);
    logic              rx_full;
    logic              rx_push;
    logic [DATA_W-1:0] rx_data;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_data;
    logic              tx_pop;

    // Engine side
    modport master (
        input  rx_full,
        input  tx_empty,
        input  tx_data,
        output rx_push,
        output rx_data,
        output tx_pop
    );

    // FIFO side
    modport slave (
        output rx_full,
        output tx_empty,
        output tx_data,
        input  rx_push,
        input  rx_data,
        input  tx_pop
    );
endinterface

// File: rtl/shift_engine.sv
// shift_engine
// ------------
// Parametrised ISR/OSR shift engine for one PIO state machine. It executes the
// IN, OUT, PUSH and PULL shift semantics in a single divided-clock step. It
// raises a combinational stall whenever a FIFO condition blocks the current
// command. A stalled command changes no state and issues no FIFO strobe. The
// decode logic simply holds the command until stall drops.
//
// Optional feature macro: SHIFT_ENGINE_AUTO_EN
//   defined   : autopush on IN and autopull on OUT are compiled in.
//   undefined : auto_push, auto_pull and the thresholds are ignored by IN/OUT.
//               IN/OUT never stall, push or pop. An empty OSR shifts out zeros.
//               Explicit PUSH/PULL with cmd_cond still use the thresholds.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   penable                 divided-clock enable; gates every strobe and update
//   dir_in, dir_out         0 = left/MSB-first, 1 = right/LSB-first
//   auto_push, auto_pull    autopush/autopull enables
//   isr_threshold,
//   osr_threshold           thresholds (field 0 means DATA_W)
//   in_cmd, out_cmd,
//   push_cmd, pull_cmd      command strobes; priority pull > push > out > in
//   cmd_count               IN/OUT bit count (field 0 means DATA_W)
//   cmd_block, cmd_cond     PUSH/PULL block flag and IfFull/IfEmpty qualifier
//   in_data                 IN source value
//   pull_fallback           OSR load value for a non-blocking PULL on empty TX
//   fifo                    RX/TX FIFO handshake bundle (shift_engine_if.master)
//   out_data                OUT result, right-justified, zero-extended
//   stall                   current command cannot complete this cycle
//   isr, osr                register contents
//   isr_count, osr_count    shift counters, saturating at DATA_W
module shift_engine #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              penable,
    input  logic              dir_in,
    input  logic              dir_out,
    input  logic              auto_push,
    input  logic              auto_pull,
    input  logic [CNT_W-1:0]  isr_threshold,
    input  logic [CNT_W-1:0]  osr_threshold,
    input  logic              in_cmd,
    input  logic              out_cmd,
    input  logic              push_cmd,
    input  logic              pull_cmd,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_block,
    input  logic              cmd_cond,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] pull_fallback,
    shift_engine_if.master    fifo,
    output logic [DATA_W-1:0] out_data,
    output logic              stall,
    output logic [DATA_W-1:0] isr,
    output logic [DATA_W-1:0] osr,
    output logic [CNT_W:0]    isr_count,
    output logic [CNT_W:0]    osr_count
);

    // Counters are one bit wider than the fields so they can hold DATA_W itself.
    localparam int           CW   = CNT_W + 1;
    localparam logic [CW-1:0] FULL = CW'(DATA_W);

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_IN,
        CMD_OUT,
        CMD_PUSH,
        CMD_PULL
    } cmd_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Count/threshold field decode: 0 stands for a full register.
    function automatic logic [CW-1:0] decode_cnt(input logic [CNT_W-1:0] f);
        return (f == '0) ? FULL : {1'b0, f};
    endfunction

    // Counter add that saturates at DATA_W.
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                              input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, FULL}) ? FULL : s[CW-1:0];
    endfunction

    // Mask of the n low bits. A shift by DATA_W clears the vector, so n = DATA_W
    // yields all ones without a special case.
    function automatic logic [DATA_W-1:0] low_mask(input logic [CW-1:0] n);
        return ~({DATA_W{1'b1}} << n);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] isr_q, isr_nxt;
    logic [DATA_W-1:0] osr_q, osr_nxt;
    logic [CW-1:0]     isr_cnt_q, isr_cnt_nxt;
    logic [CW-1:0]     osr_cnt_q, osr_cnt_nxt;

    // ------------------------------------------------------------------
    // Command decode and operand preparation
    // ------------------------------------------------------------------
    cmd_e              cmd;
    logic [CW-1:0]     n;
    logic [CW-1:0]     isr_thr;
    logic [CW-1:0]     osr_thr;
    logic [DATA_W-1:0] in_bits;
    logic [DATA_W-1:0] in_shift;
    logic [CW-1:0]     in_cnt;
    logic              push_due;
    logic              refill;
    logic [DATA_W-1:0] eff_osr;
    logic [CW-1:0]     eff_cnt;

    always_comb begin
        cmd = CMD_NONE;
        if (pull_cmd)      cmd = CMD_PULL;
        else if (push_cmd) cmd = CMD_PUSH;
        else if (out_cmd)  cmd = CMD_OUT;
        else if (in_cmd)   cmd = CMD_IN;
    end

    assign n       = decode_cnt(cmd_count);
    assign isr_thr = decode_cnt(isr_threshold);
    assign osr_thr = decode_cnt(osr_threshold);

    // IN: the new bits enter at the LSB end (left shift) or at the MSB end
    // (right shift).
    assign in_bits  = in_data & low_mask(n);
    assign in_shift = dir_in ? ((isr_q >> n) | (in_bits << (FULL - n)))
                             : ((isr_q << n) | in_bits);
    assign in_cnt   = sat_add(isr_cnt_q, n);

`ifdef SHIFT_ENGINE_AUTO_EN
    // Autopush looks at the post-shift count. Autopull looks at the count
    // before the shift, and a refill is consumed by the same OUT.
    assign push_due = auto_push && (in_cnt >= isr_thr);
    assign refill   = auto_pull && (osr_cnt_q >= osr_thr);
`else
    logic unused_auto;
    assign unused_auto = ^{auto_push, auto_pull};
    assign push_due    = 1'b0;
    assign refill      = 1'b0;
`endif

    assign eff_osr = refill ? fifo.tx_data : osr_q;
    assign eff_cnt = refill ? '0 : osr_cnt_q;

    // ------------------------------------------------------------------
    // Command execution
    // ------------------------------------------------------------------
    logic              stall_c;
    logic              rx_push_c;
    logic              tx_pop_c;
    logic [DATA_W-1:0] rx_data_c;
    logic [DATA_W-1:0] out_data_c;

    always_comb begin
        isr_nxt     = isr_q;
        isr_cnt_nxt = isr_cnt_q;
        osr_nxt     = osr_q;
        osr_cnt_nxt = osr_cnt_q;
        stall_c     = 1'b0;
        rx_push_c   = 1'b0;
        tx_pop_c    = 1'b0;
        rx_data_c   = isr_q;
        out_data_c  = '0;

        unique case (cmd)
            CMD_PULL: begin
                if (cmd_cond && (osr_cnt_q < osr_thr)) begin
                    // IfEmpty with OSR not yet drained: completes as a no-op.
                end else if (fifo.tx_empty) begin
                    if (cmd_block) begin
                        stall_c = 1'b1;
                    end else begin
                        osr_nxt     = pull_fallback;
                        osr_cnt_nxt = '0;
                    end
                end else begin
                    tx_pop_c    = 1'b1;
                    osr_nxt     = fifo.tx_data;
                    osr_cnt_nxt = '0;
                end
            end

            CMD_PUSH: begin
                if (cmd_cond && (isr_cnt_q < isr_thr)) begin
                    // IfFull with ISR not yet filled: completes as a no-op.
                end else if (fifo.rx_full && cmd_block) begin
                    stall_c = 1'b1;
                end else begin
                    // A non-blocking push onto a full FIFO drops the word
                    // but still clears the ISR.
                    rx_push_c   = !fifo.rx_full;
                    isr_nxt     = '0;
                    isr_cnt_nxt = '0;
                end
            end

            CMD_OUT: begin
                if (refill && fifo.tx_empty) begin
                    stall_c = 1'b1;
                end else begin
                    tx_pop_c    = refill;
                    out_data_c  = dir_out ? (eff_osr & low_mask(n))
                                          : (eff_osr >> (FULL - n));
                    osr_nxt     = dir_out ? (eff_osr >> n) : (eff_osr << n);
                    osr_cnt_nxt = sat_add(eff_cnt, n);
                end
            end

            CMD_IN: begin
                rx_data_c = in_shift;
                if (push_due) begin
                    if (fifo.rx_full) begin
                        stall_c = 1'b1;
                    end else begin
                        rx_push_c   = 1'b1;
                        isr_nxt     = '0;
                        isr_cnt_nxt = '0;
                    end
                end else begin
                    isr_nxt     = in_shift;
                    isr_cnt_nxt = in_cnt;
                end
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output gating
    // ------------------------------------------------------------------
    // Strobes and stall exist only on enabled cycles. They are also forced low
    // while reset is held, so nothing is issued once reset asserts.
    logic active;
    logic commit;

    assign active       = penable && !reset;
    assign commit       = penable && !stall_c;

    assign stall        = active && stall_c;
    assign fifo.rx_push = active && rx_push_c;
    assign fifo.tx_pop  = active && tx_pop_c;
    assign fifo.rx_data = rx_data_c;
    assign out_data     = out_data_c;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isr_q     <= '0;
            isr_cnt_q <= '0;
            osr_q     <= '0;
            osr_cnt_q <= FULL;  // OSR starts empty
        end else if (commit) begin
            isr_q     <= isr_nxt;
            isr_cnt_q <= isr_cnt_nxt;
            osr_q     <= osr_nxt;
            osr_cnt_q <= osr_cnt_nxt;
        end
    end

    assign isr       = isr_q;
    assign osr       = osr_q;
    assign isr_count = isr_cnt_q;
    assign osr_count = osr_cnt_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb_shift_engine
// ---------------
// Directed scoreboard bench for shift_engine (DATA_W = 32).
//
// Each driven cycle pushes one expected record. The monitor pops that record
// at the falling edge and compares the combinational outputs: stall, rx_push,
// tx_pop, and rx_data/out_data where they matter. It then compares the
// register state just after the following rising edge. The expected values are
// hand-computed constants.
module tb_shift_engine;

    localparam int DW = 32;
    localparam int CW = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT inputs ----------------
    logic          penable, dir_in, dir_out, auto_push, auto_pull;
    logic [CW-1:0] isr_threshold, osr_threshold, cmd_count;
    logic          in_cmd, out_cmd, push_cmd, pull_cmd, cmd_block, cmd_cond;
    logic [DW-1:0] in_data, pull_fallback;

    // ---------------- DUT outputs ----------------
    logic [DW-1:0] out_data, isr, osr;
    logic          stall;
    logic [CW:0]   isr_count, osr_count;

    shift_engine_if #(.DATA_W(DW)) fifo_if ();

    shift_engine #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .penable       (penable),
        .dir_in        (dir_in),
        .dir_out       (dir_out),
        .auto_push     (auto_push),
        .auto_pull     (auto_pull),
        .isr_threshold (isr_threshold),
        .osr_threshold (osr_threshold),
        .in_cmd        (in_cmd),
        .out_cmd       (out_cmd),
        .push_cmd      (push_cmd),
        .pull_cmd      (pull_cmd),
        .cmd_count     (cmd_count),
        .cmd_block     (cmd_block),
        .cmd_cond      (cmd_cond),
        .in_data       (in_data),
        .pull_fallback (pull_fallback),
        .fifo          (fifo_if),
        .out_data      (out_data),
        .stall         (stall),
        .isr           (isr),
        .osr           (osr),
        .isr_count     (isr_count),
        .osr_count     (osr_count)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic          stall;
        logic          rx_push;
        logic [DW-1:0] rx_data;
        logic          tx_pop;
        logic          out_chk;
        logic [DW-1:0] out_data;
        logic [DW-1:0] isr;
        logic [CW:0]   isr_count;
        logic [DW-1:0] osr;
        logic [CW:0]   osr_count;
    } exp_t;

    exp_t exp_q[$];
    logic mon_valid = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic st, input logic rp, input logic [DW-1:0] rd,
                                input logic tp, input logic oc, input logic [DW-1:0] od,
                                input logic [DW-1:0] i, input logic [CW:0] ic,
                                input logic [DW-1:0] o, input logic [CW:0] occ);
        exp_t e;
        e.stall = st;  e.rx_push = rp; e.rx_data = rd; e.tx_pop = tp;
        e.out_chk = oc; e.out_data = od;
        e.isr = i; e.isr_count = ic; e.osr = o; e.osr_count = occ;
        return e;
    endfunction

    // Monitor: combinational outputs at the falling edge, state after the next
    // rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL queue_underflow: got empty queue required a record");
                end else begin
                    e = exp_q.pop_front();
                    check("stall",   DW'(stall),           DW'(e.stall));
                    check("rx_push", DW'(fifo_if.rx_push), DW'(e.rx_push));
                    check("tx_pop",  DW'(fifo_if.tx_pop),  DW'(e.tx_pop));
                    if (e.rx_push) check("rx_data", fifo_if.rx_data, e.rx_data);
                    if (e.out_chk) check("out_data", out_data, e.out_data);
                    @(posedge clk);
                    #1;
                    check("isr",       isr,            e.isr);
                    check("isr_count", DW'(isr_count), DW'(e.isr_count));
                    check("osr",       osr,            e.osr);
                    check("osr_count", DW'(osr_count), DW'(e.osr_count));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        in_cmd = 0; out_cmd = 0; push_cmd = 0; pull_cmd = 0;
        cmd_block = 0; cmd_cond = 0;
    endtask

    task automatic set_in(input logic d, input logic [CW-1:0] c, input logic [DW-1:0] v);
        idle(); in_cmd = 1; dir_in = d; cmd_count = c; in_data = v;
    endtask

    task automatic set_out(input logic d, input logic [CW-1:0] c);
        idle(); out_cmd = 1; dir_out = d; cmd_count = c;
    endtask

    task automatic set_push(input logic blk, input logic cond);
        idle(); push_cmd = 1; cmd_block = blk; cmd_cond = cond;
    endtask

    task automatic set_pull(input logic blk, input logic cond);
        idle(); pull_cmd = 1; cmd_block = blk; cmd_cond = cond;
    endtask

    // Apply the current inputs for one cycle and hand the expectation over.
    task automatic issue(input exp_t e);
        exp_q.push_back(e);
        mon_valid = 1'b1;
        @(posedge clk);
        #2;
        mon_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required end of sequence");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        penable = 1; dir_in = 0; dir_out = 0; auto_push = 0; auto_pull = 0;
        isr_threshold = '0; osr_threshold = '0; cmd_count = '0;
        in_data = '0; pull_fallback = '0;
        fifo_if.rx_full = 0; fifo_if.tx_empty = 1; fifo_if.tx_data = '0;
        idle();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Reset state
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32));

`ifdef SHIFT_ENGINE_AUTO_EN
        // OUT with autopull from an empty OSR: refill and shift in one step.
        auto_pull = 1; fifo_if.tx_empty = 0; fifo_if.tx_data = 32'hA5C3_1E7F;
        set_out(1, 8);
        issue(mk(0, 0, 0, 1, 1, 32'h7F, 0, 0, 32'h00A5_C31E, 8));
        set_out(1, 0);   // count 8 < 32: no refill, drains all 32 bits
        issue(mk(0, 0, 0, 0, 1, 32'h00A5_C31E, 0, 0, 0, 32));
        fifo_if.tx_empty = 1;
        set_out(1, 8);   // refill needed, nothing available
        issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32));
        auto_pull = 0; fifo_if.tx_empty = 0;

        // Autopush on the fourth byte, first held off by rx_full.
        auto_push = 1;
        set_in(0, 8, 32'h11); issue(mk(0, 0, 0, 0, 0, 0, 32'h11, 8, 0, 32));
        set_in(0, 8, 32'h22); issue(mk(0, 0, 0, 0, 0, 0, 32'h1122, 16, 0, 32));
        set_in(0, 8, 32'h33); issue(mk(0, 0, 0, 0, 0, 0, 32'h11_2233, 24, 0, 32));
        fifo_if.rx_full = 1;
        set_in(0, 8, 32'h44);
        repeat (3) issue(mk(1, 0, 0, 0, 0, 0, 32'h11_2233, 24, 0, 32));
        fifo_if.rx_full = 0;
        issue(mk(0, 1, 32'h1122_3344, 0, 0, 0, 0, 0, 0, 32));
        auto_push = 0;
        do_reset();
`else
        // Auto enables have no effect on IN/OUT: an empty OSR shifts out zeros.
        auto_pull = 1; fifo_if.tx_empty = 0; fifo_if.tx_data = 32'hA5C3_1E7F;
        set_out(1, 8);
        issue(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 32));
        auto_pull = 0;
        auto_push = 1; fifo_if.rx_full = 1;
        set_in(0, 8, 32'h11); issue(mk(0, 0, 0, 0, 0, 0, 32'h11, 8, 0, 32));
        set_in(0, 8, 32'h22); issue(mk(0, 0, 0, 0, 0, 0, 32'h1122, 16, 0, 32));
        set_in(0, 8, 32'h33); issue(mk(0, 0, 0, 0, 0, 0, 32'h11_2233, 24, 0, 32));
        set_in(0, 8, 32'h44); issue(mk(0, 0, 0, 0, 0, 0, 32'h1122_3344, 32, 0, 32));
        auto_push = 0; fifo_if.rx_full = 0;
        do_reset();
`endif

        // PULL variants on an empty TX FIFO
        fifo_if.tx_empty = 1; pull_fallback = 32'hDEAD_BEEF;
        set_pull(0, 0); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0));
        set_pull(1, 0); issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0));
        fifo_if.tx_empty = 0; fifo_if.tx_data = 32'hA5C3_1E7F;
        set_pull(1, 1); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0));
        set_pull(1, 0); issue(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'hA5C3_1E7F, 0));

        // OUT in both directions
        set_out(1, 8); issue(mk(0, 0, 0, 0, 1, 32'h7F, 0, 0, 32'h00A5_C31E, 8));
        set_out(0, 8); issue(mk(0, 0, 0, 0, 1, 32'h00, 0, 0, 32'hA5C3_1E00, 16));
        set_out(0, 4); issue(mk(0, 0, 0, 0, 1, 32'hA, 0, 0, 32'h5C31_E000, 20));

        // Priority: pull wins over push, out and in
        fifo_if.tx_data = 32'h1234_5678;
        idle();
        in_cmd = 1; in_data = 32'hFF; cmd_count = 8; out_cmd = 1;
        push_cmd = 1; pull_cmd = 1; cmd_block = 1;
        issue(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h1234_5678, 0));

        // IN left, then explicit PUSH
        set_in(0, 8, 32'h11); issue(mk(0, 0, 0, 0, 0, 0, 32'h11, 8, 32'h1234_5678, 0));
        set_in(0, 8, 32'h22); issue(mk(0, 0, 0, 0, 0, 0, 32'h1122, 16, 32'h1234_5678, 0));
        set_in(0, 8, 32'h33); issue(mk(0, 0, 0, 0, 0, 0, 32'h11_2233, 24, 32'h1234_5678, 0));
        set_in(0, 8, 32'h44); issue(mk(0, 0, 0, 0, 0, 0, 32'h1122_3344, 32, 32'h1234_5678, 0));
        set_push(0, 0); issue(mk(0, 1, 32'h1122_3344, 0, 0, 0, 0, 0, 32'h1234_5678, 0));

        // IN right with source masking, then PUSH IfFull against threshold 16
        set_in(1, 8, 32'hAB); issue(mk(0, 0, 0, 0, 0, 0, 32'hAB00_0000, 8, 32'h1234_5678, 0));
        set_in(1, 4, 32'hF5); issue(mk(0, 0, 0, 0, 0, 0, 32'h5AB0_0000, 12, 32'h1234_5678, 0));
        isr_threshold = 5'd16;
        set_push(0, 1); issue(mk(0, 0, 0, 0, 0, 0, 32'h5AB0_0000, 12, 32'h1234_5678, 0));
        set_in(1, 4, 32'h0C); issue(mk(0, 0, 0, 0, 0, 0, 32'hC5AB_0000, 16, 32'h1234_5678, 0));
        set_push(0, 1); issue(mk(0, 1, 32'hC5AB_0000, 0, 0, 0, 0, 0, 32'h1234_5678, 0));
        isr_threshold = '0;

        // Full-width IN, then PUSH against a full RX FIFO
        set_in(0, 0, 32'hCAFE_F00D); issue(mk(0, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 32, 32'h1234_5678, 0));
        fifo_if.rx_full = 1;
        set_push(1, 0); issue(mk(1, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 32, 32'h1234_5678, 0));
        set_push(0, 0); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678, 0));
        fifo_if.rx_full = 0;

        // penable gating around a full-width OUT
        fifo_if.tx_data = 32'h8000_0001;
        set_pull(1, 0); issue(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8000_0001, 0));
        penable = 0;
        set_out(1, 0); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h8000_0001, 0));
        penable = 1;
        issue(mk(0, 0, 0, 0, 1, 32'h8000_0001, 0, 0, 0, 32));
        penable = 0; fifo_if.tx_empty = 1;
        set_pull(1, 0); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32));
        penable = 1;

        // Reset asserted while a blocking PULL is stalled
        pull_fallback = 32'h0BAD_F00D;
        set_pull(0, 0); issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0));
        set_pull(1, 0); issue(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 0));
        reset = 1'b1;
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32));
        reset = 1'b0;
        idle();
        issue(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32));

        repeat (2) @(posedge clk);
        check("queue_drained", DW'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised ISR/OSR shift engine with autopush/autopull and FIFO handshakes, replacing the fixed 32-bit, handshake-less shifters inside each PIO state machine. It executes IN, OUT, PUSH and PULL shift semantics in one divided-clock step and asserts a combinational stall whenever a FIFO condition blocks the instruction. It sits between the state machine's execute decode and the per-machine TX/RX FIFOs.

## Interface
- DATA_W, 32: shift register width; legal values 8, 16, 32.
- CNT_W, $clog2(DATA_W): width of the count/threshold fields; a field value of 0 encodes DATA_W.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- penable  in  1  divided-clock enable; state changes only when high.
- dir_in, dir_out  in  1 each  shift direction per register; 0 = left/MSB-first, 1 = right/LSB-first.
- auto_push, auto_pull  in  1 each  autopush/autopull enables.
- isr_threshold, osr_threshold  in  CNT_W each  autopush/autopull thresholds; 0 = DATA_W.
- in_cmd  in  1  IN strobe.
- out_cmd  in  1  OUT strobe.
- push_cmd, pull_cmd  in  1 each  explicit PUSH/PULL strobes.
- cmd_count  in  CNT_W  bit count for IN/OUT; 0 = DATA_W.
- cmd_block  in  1  block flag for PUSH/PULL.
- cmd_cond  in  1  IfFull (PUSH) / IfEmpty (PULL) qualifier.
- in_data  in  DATA_W  IN source value.
- pull_fallback  in  DATA_W  value loaded by a non-blocking PULL on an empty FIFO (X register).
- rx_full  in  1  RX FIFO full.
- rx_push  out  1  RX write strobe.
- rx_data  out  DATA_W  RX write data.
- tx_empty  in  1  TX FIFO empty.
- tx_data  in  DATA_W  TX head word.
- tx_pop  out  1  TX read strobe.
- out_data  out  DATA_W  OUT result, right-justified, zero-extended.
- stall  out  1  current command cannot complete.
- isr, osr  out  DATA_W each  register contents.
- isr_count, osr_count  out  CNT_W+1 each  shift counters.

## Operation
- Reset: isr = 0, isr_count = 0, osr = 0, osr_count = DATA_W (OSR empty). rx_push, tx_pop, and stall are combinational and are 0 while no command is asserted.
- Command priority when more than one strobe is high: pull > push > out > in. Lower-priority strobes are ignored.
- n = cmd_count, with 0 mapped to DATA_W. Counters saturate at DATA_W.
- IN, left: isr = (isr << n) | in_data[n-1:0]. IN, right: isr = (isr >> n) | (in_data[n-1:0] << (DATA_W-n)). isr_count += n.
  - Autopush fires when the new count reaches or exceeds the threshold.
  - If rx_full: stall, with no state change.
  - Otherwise: rx_push = 1, rx_data = the shifted value, then isr = 0 and isr_count = 0.
- OUT: autopull refill is needed when osr_count >= osr_threshold.
  - If a refill is needed and tx_empty: stall.
  - If a refill is needed and a word is available: tx_pop = 1, the effective OSR is tx_data with count 0, and the shift uses it in the same cycle.
  - Left: out_data = effective_osr[DATA_W-1 -: n] and osr <<= n. Right: out_data = effective_osr[n-1:0] and osr >>= n. osr_count += n.
- PUSH: a no-op if cmd_cond is set and isr_count < isr_threshold.
  - rx_full with cmd_block: stall.
  - rx_full without cmd_block: no write, but the ISR is still cleared.
  - Otherwise: rx_push = 1 and the ISR is cleared.
- PULL: a no-op if cmd_cond is set and osr_count < osr_threshold.
  - tx_empty with cmd_block: stall.
  - tx_empty without cmd_block: osr = pull_fallback, osr_count = 0.
  - Otherwise: tx_pop = 1, osr = tx_data, osr_count = 0.
- While stall is high, nothing updates and rx_push and tx_pop stay 0. The command is retried every enabled cycle until it completes.

## Timing
- stall, rx_push, tx_pop, rx_data, and out_data are combinational from the commands, the FIFO flags, and the registers. They are gated by penable: when penable = 0, strobes are 0 and stall is 0.
- Registers update on the rising clk edge when penable = 1 and stall = 0. Commands complete with zero added latency.
- rx_full and tx_empty are sampled in the same cycle the command is asserted. Simultaneous pop and push on the FIFOs is legal.
- Reset asserted mid-stall clears all state immediately. No strobe is issued after reset asserts.

## Configuration
- SHIFT_ENGINE_AUTO_EN defined: autopush/autopull logic is compiled in as described above.
- SHIFT_ENGINE_AUTO_EN undefined:
  - auto_push, auto_pull, and the thresholds are ignored.
  - IN and OUT never stall, push, or pop.
  - OUT on an empty OSR shifts out zeros.
  - Explicit PUSH/PULL cmd_cond still uses the thresholds.

## Test plan
- Reset, then OUT n=8, dir right, auto_pull=1, threshold 0, tx_data=0xA5C3_1E7F, tx_empty=0 -> tx_pop=1, out_data=0x7F, osr=0x00A5_C31E, osr_count=8.
- Four IN n=8, dir left, in_data=0x11,0x22,0x33,0x44, auto_push=1, threshold 0, rx_full=0 -> 4th cycle rx_push=1, rx_data=0x1122_3344, isr=0, isr_count=0.
- Same as previous but rx_full=1 at the 4th IN -> stall=1 for 3 cycles, isr holds 0x0011_2233. Release rx_full -> push of 0x1122_3344.
- PULL noblock with tx_empty=1, pull_fallback=0xDEAD_BEEF -> no tx_pop, osr=0xDEAD_BEEF, osr_count=0. PULL block with tx_empty=1 -> stall=1, osr unchanged.
- PUSH IfFull with isr_count=12, threshold 16 -> no rx_push, isr unchanged. With isr_count=16 -> rx_push=1, isr cleared.
- penable toggling 1/0 during an OUT n=32 -> state changes only on enabled cycles. Reset asserted while stalled -> osr_count=32, stall=0.
